// File: rtl/display_pkg.sv
// Shared display-mode encoding and key-FSM states for the display front end.
// The source selector decodes display_mode_e directly.
package display_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'b00,
        MODE_SECONDS   = 2'b01,
        MODE_STOPWATCH = 2'b10,
        MODE_OFF       = 2'b11
    } display_mode_e;

    typedef enum logic [1:0] {
        KEY_IDLE      = 2'b00,
        KEY_HELD      = 2'b01,
        KEY_HOLD_LONG = 2'b10
    } key_state_e;

    // Short press walks the visible modes; from OFF it wakes into CLOCK.
    function automatic display_mode_e short_next(input display_mode_e mode);
        display_mode_e result;
        case (mode)
            MODE_CLOCK:     result = MODE_SECONDS;
            MODE_SECONDS:   result = MODE_STOPWATCH;
            MODE_STOPWATCH: result = MODE_CLOCK;
            MODE_OFF:       result = MODE_CLOCK;
            default:        result = MODE_CLOCK;
        endcase
        return result;
    endfunction

    function automatic display_mode_e long_next(input display_mode_e mode);
        display_mode_e result;
        case (mode)
            MODE_OFF: result = MODE_CLOCK;
            default:  result = MODE_OFF;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus stability counter for one active-low push button.
// press/release pulse on the same cycle the debounced level is about to flip.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;
    logic             flip_s;

    assign flip_s = (sync2_r != level_r) && (cnt_r == CNT_LAST);

    // Synchronise the pin and only accept a level that stayed different long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            cnt_r   <= '0;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (flip_s) begin
                level_r <= sync2_r;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign level         = level_r;
    assign press_pulse   = flip_s & ~sync2_r;
    assign release_pulse = flip_s & sync2_r;

endmodule

// File: rtl/display_mode_controller.sv
// Drives the source selector's select/enable from one button: short press cycles
// modes, long press toggles the display off; colon blinks in clock mode.
module display_mode_controller
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int BLINK_CYCLES    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode_n,
    output logic [1:0] select,
    output logic       enable,
    output logic       mode_strobe
);

    localparam int HOLD_W  = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic                db_level_s;
    logic                press_s;
    logic                release_s;
    key_state_e          state_r;
    key_state_e          state_nxt_s;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [HOLD_W-1:0]   hold_cnt_nxt_s;
    display_mode_e       mode_r;
    display_mode_e       mode_nxt_s;
    logic                strobe_r;
    logic                enable_r;
    logic [BLINK_W-1:0]  blink_cnt_r;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clk           (clk),
        .rst           (rst),
        .key_n         (key_mode_n),
        .level         (db_level_s),
        .press_pulse   (press_s),
        .release_pulse (release_s)
    );

    // Press classification; the mode action is taken on the same edge as the transition.
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        mode_nxt_s     = mode_r;
        case (state_r)
            KEY_IDLE: begin
                if (press_s) begin
                    state_nxt_s    = KEY_HELD;
                    hold_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = KEY_IDLE;
                end
            end
            KEY_HELD: begin
                if (release_s) begin
                    mode_nxt_s     = short_next(mode_r);
                    state_nxt_s    = KEY_IDLE;
                    hold_cnt_nxt_s = '0;
                end else if (db_level_s) begin
                    // Released without a pulse cannot happen; recover quietly.
                    state_nxt_s    = KEY_IDLE;
                    hold_cnt_nxt_s = '0;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    mode_nxt_s  = long_next(mode_r);
                    state_nxt_s = KEY_HOLD_LONG;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
                end
            end
            KEY_HOLD_LONG: begin
                if (release_s) begin
                    state_nxt_s    = KEY_IDLE;
                    hold_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = KEY_HOLD_LONG;
                end
            end
            default: begin
                state_nxt_s    = KEY_IDLE;
                hold_cnt_nxt_s = '0;
            end
        endcase
    end

    // Key FSM, mode register and change strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= KEY_IDLE;
            hold_cnt_r <= '0;
            mode_r     <= MODE_CLOCK;
            strobe_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            mode_r     <= mode_nxt_s;
            strobe_r   <= (mode_nxt_s != mode_r);
        end
    end

    // Colon blink: free-running only while clock mode persists, restarted lit on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_r    <= 1'b1;
            blink_cnt_r <= '0;
        end else if ((mode_nxt_s != MODE_CLOCK) || (mode_r != MODE_CLOCK)) begin
            enable_r    <= 1'b1;
            blink_cnt_r <= '0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            enable_r    <= ~enable_r;
            blink_cnt_r <= '0;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
    end

    assign select      = mode_r;
    assign enable      = enable_r;
    assign mode_strobe = strobe_r;

endmodule
